// File: rtl/qupls_rt_free_list_pkg.sv
// Shared types and defaults for the Rt physical-register free list.
package qupls_rt_free_list_pkg;

    localparam int FL_PREGS = 256;
    localparam int FL_RESV  = 64;
    localparam int FL_PW    = $clog2(FL_PREGS);

    typedef logic [FL_PW-1:0] pregno_t;

    typedef enum logic {FL_INIT, FL_RUN} fl_state_t;

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/qupls_fl_ram.sv
// Free-list storage: two async read ports, two write ports, no reset (INIT fills it).
module qupls_fl_ram #(
    parameter int PREGS = 256,
    parameter int PW    = 8
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [PW-1:0] wa0,
    input  logic [PW-1:0] wd0,
    input  logic          we1,
    input  logic [PW-1:0] wa1,
    input  logic [PW-1:0] wd1,
    input  logic [PW-1:0] ra0,
    input  logic [PW-1:0] ra1,
    output logic [PW-1:0] rd0,
    output logic [PW-1:0] rd1
);

    logic [PW-1:0] mem [PREGS];

    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/qupls_rt_free_list.sv
// Rt physical-register allocator: speculative head, committed head and tail over a circular list.
module qupls_rt_free_list
    import qupls_rt_free_list_pkg::*;
#(
    parameter  int PREGS = FL_PREGS,
    parameter  int RESV  = FL_RESV,
    localparam int PW    = $clog2(PREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ready,
    input  logic [1:0]    alloc_req,
    output logic          alloc_ok,
    output logic [PW-1:0] alloc_tag0,
    output logic [PW-1:0] alloc_tag1,
    input  logic [1:0]    cmt_n,
    input  logic [1:0]    free_v,
    input  logic [PW-1:0] free_tag0,
    input  logic [PW-1:0] free_tag1,
    input  logic          flush,
    output logic [PW:0]   avail,
    output logic          ovf_err
);

    fl_state_t     state, state_nxt;
    logic [PW:0]   head, chead, tail;
    logic [PW:0]   head_nxt, chead_nxt, tail_nxt;
    logic [PW:0]   space;
    logic [1:0]    nreq;
    logic          init_we, init_last;
    logic          fwe0, fwe1, free_drop, cmt_bad;
    logic          we0;
    logic [PW-1:0] wd0, wa1, rd0, rd1;

    // FSM: state register / next state / outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FL_INIT;
        else        state <= state_nxt;
    end

    assign init_last = (tail == (PW+1)'(PREGS - RESV - 1));

    always_comb begin
        state_nxt = state;
        if (state == FL_INIT && init_last) state_nxt = FL_RUN;
    end

    always_comb begin
        ready   = 1'b0;
        init_we = 1'b0;
        case (state)
            FL_INIT: init_we = 1'b1;
            FL_RUN:  ready   = 1'b1;
            default: ;
        endcase
    end

    // Allocation is all-or-nothing; reads come straight from registered pointers
    assign avail      = tail - head;
    assign nreq       = pop2(alloc_req);
    assign alloc_ok   = ready & ~flush & (nreq != 2'd0) & (avail >= (PW+1)'(nreq));
    assign alloc_tag0 = ready ? rd0 : '0;
    assign alloc_tag1 = ready ? rd1 : '0;

    // Room left is measured against the committed head, not the speculative one
    assign space     = (PW+1)'(PREGS) - (tail - chead);
    assign fwe0      = ready & free_v[0] & (space != '0);
    assign fwe1      = ready & free_v[1] & (space > (PW+1)'(free_v[0]));
    assign free_drop = ready & ((free_v[0] & ~fwe0) | (free_v[1] & ~fwe1));
    assign cmt_bad   = ready & ((PW+1)'(cmt_n) > (head - chead));

    always_comb begin
        chead_nxt = chead;
        head_nxt  = head;
        if (ready) begin
            chead_nxt = cmt_bad ? head : chead + (PW+1)'(cmt_n);
            if (flush)         head_nxt = chead_nxt;
            else if (alloc_ok) head_nxt = head + (PW+1)'(nreq);
        end
        if (init_we) tail_nxt = tail + (PW+1)'(1);
        else         tail_nxt = tail + (PW+1)'(fwe0) + (PW+1)'(fwe1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            chead   <= '0;
            tail    <= '0;
            ovf_err <= 1'b0;
        end else begin
            head    <= head_nxt;
            chead   <= chead_nxt;
            tail    <= tail_nxt;
            ovf_err <= ovf_err | free_drop | cmt_bad;
        end
    end

    // INIT borrows write port 0 to seed tags RESV..PREGS-1
    assign we0 = init_we | fwe0;
    assign wd0 = init_we ? PW'(RESV) + tail[PW-1:0] : free_tag0;
    assign wa1 = tail[PW-1:0] + PW'(free_v[0]);

    qupls_fl_ram #(.PREGS(PREGS), .PW(PW)) u_ram (
        .clk (clk),
        .we0 (we0),
        .wa0 (tail[PW-1:0]),
        .wd0 (wd0),
        .we1 (fwe1),
        .wa1 (wa1),
        .wd1 (free_tag1),
        .ra0 (head[PW-1:0]),
        .ra1 (head[PW-1:0] + PW'(1)),
        .rd0 (rd0),
        .rd1 (rd1)
    );

endmodule

// File: tb/tb_qupls_rt_free_list.sv
// Directed bench for qupls_rt_free_list with hand-computed pointer/tag expectations.
module tb_qupls_rt_free_list;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ready;
    logic [1:0]    alloc_req;
    logic          alloc_ok;
    logic [PW-1:0] alloc_tag0, alloc_tag1;
    logic [1:0]    cmt_n;
    logic [1:0]    free_v;
    logic [PW-1:0] free_tag0, free_tag1;
    logic          flush;
    logic [PW:0]   avail;
    logic          ovf_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    qupls_rt_free_list dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready      (ready),
        .alloc_req  (alloc_req),
        .alloc_ok   (alloc_ok),
        .alloc_tag0 (alloc_tag0),
        .alloc_tag1 (alloc_tag1),
        .cmt_n      (cmt_n),
        .free_v     (free_v),
        .free_tag0  (free_tag0),
        .free_tag1  (free_tag1),
        .flush      (flush),
        .avail      (avail),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 2'b00; free_v = 2'b00; cmt_n = 2'd0; flush = 1'b0;
        free_tag0 = '0; free_tag1 = '0;
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (!ready && n < 400) begin
            cyc();
            n++;
        end
        chk(tag, n, 192);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        chk("rst_ready", ready, 0);
        chk("rst_avail", avail, 0);
        chk("rst_ok", alloc_ok, 0);
        chk("rst_tag0", alloc_tag0, 0);
        chk("rst_ovf", ovf_err, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        wait_ready("init_cycles");
        #1;
        chk("init_avail", avail, 192);
        chk("init_tag0", alloc_tag0, 64);
        chk("init_tag1", alloc_tag1, 65);

        // drain all 192 tags two per cycle
        for (int i = 0; i < 96; i++) begin
            alloc_req = 2'b11; #1;
            chk("drain_ok", alloc_ok, 1);
            chk("drain_tag0", alloc_tag0, 64 + 2*i);
            chk("drain_tag1", alloc_tag1, 65 + 2*i);
            cyc();
        end
        #1;
        chk("empty_avail", avail, 0);
        chk("empty_ok", alloc_ok, 0);
        cyc();
        chk("empty_hold", avail, 0);

        // one tag available, two requested
        alloc_req = 2'b00; free_v = 2'b01; free_tag0 = 8'd100; #1;
        chk("no_bypass", avail, 0);
        cyc();
        idle(); alloc_req = 2'b11; #1;
        chk("one_avail_ok", alloc_ok, 0);
        chk("one_avail", avail, 1);
        cyc();
        chk("one_avail_hold", avail, 1);
        alloc_req = 2'b01; #1;
        chk("one_ok", alloc_ok, 1);
        chk("one_tag", alloc_tag0, 100);
        cyc();
        idle(); #1;
        chk("one_after", avail, 0);

        // retire everything allocated so far: head=chead=193
        for (int i = 0; i < 96; i++) begin
            cmt_n = 2'd2; cyc();
        end
        cmt_n = 2'd1; cyc();
        idle(); #1;
        chk("cmt_ovf", ovf_err, 0);

        // flush recovery
        for (int i = 0; i < 3; i++) begin
            free_v = 2'b11; free_tag0 = PW'(10 + 2*i); free_tag1 = PW'(11 + 2*i);
            cyc();
        end
        idle(); #1;
        chk("fl_avail6", avail, 6);
        for (int i = 0; i < 3; i++) begin
            alloc_req = 2'b11; #1;
            chk("fl_tag0", alloc_tag0, 10 + 2*i);
            chk("fl_tag1", alloc_tag1, 11 + 2*i);
            cyc();
        end
        idle(); cmt_n = 2'd2; cyc();
        idle(); flush = 1'b1; alloc_req = 2'b11; #1;
        chk("flush_ok", alloc_ok, 0);
        cyc();
        idle(); #1;
        chk("flush_avail", avail, 4);
        for (int i = 0; i < 2; i++) begin
            alloc_req = 2'b11; #1;
            chk("re_ok", alloc_ok, 1);
            chk("re_tag0", alloc_tag0, 12 + 2*i);
            chk("re_tag1", alloc_tag1, 13 + 2*i);
            cyc();
        end
        idle(); #1;
        chk("re_avail", avail, 0);

        // simultaneous alloc + free + commit at avail=2
        free_v = 2'b11; free_tag0 = 8'd20; free_tag1 = 8'd21; cyc();
        idle(); #1;
        chk("sim_pre", avail, 2);
        alloc_req = 2'b11; free_v = 2'b11; free_tag0 = 8'd7; free_tag1 = 8'd9; cmt_n = 2'd2; #1;
        chk("sim_ok", alloc_ok, 1);
        chk("sim_tag0", alloc_tag0, 20);
        chk("sim_tag1", alloc_tag1, 21);
        cyc();
        idle(); #1;
        chk("sim_avail", avail, 2);
        chk("sim_next0", alloc_tag0, 7);
        chk("sim_next1", alloc_tag1, 9);
        alloc_req = 2'b10; #1;
        chk("lane1_ok", alloc_ok, 1);
        chk("lane1_tag", alloc_tag0, 7);
        cyc();
        chk("lane1_avail", avail, 1);
        chk("lane1_next", alloc_tag0, 9);
        alloc_req = 2'b01; #1;
        chk("lane0_ok", alloc_ok, 1);
        cyc();
        idle(); #1;
        chk("lane0_avail", avail, 0);

        // fill to full: tail - chead = 6 + 250 = 256
        for (int i = 0; i < 125; i++) begin
            free_v = 2'b11; free_tag0 = PW'(2*i); free_tag1 = PW'(2*i + 1);
            cyc();
        end
        idle(); #1;
        chk("full_avail", avail, 250);
        chk("full_ovf0", ovf_err, 0);
        free_v = 2'b01; free_tag0 = 8'd33; cyc();
        idle(); #1;
        chk("full_ovf", ovf_err, 1);
        chk("full_tail", avail, 250);

        // reset mid-stream
        alloc_req = 2'b11; #1;
        chk("mid_ok", alloc_ok, 1);
        rst_n = 1'b0; #1;
        chk("mid_ready", ready, 0);
        chk("mid_avail", avail, 0);
        chk("mid_alloc_ok", alloc_ok, 0);
        chk("mid_tag0", alloc_tag0, 0);
        chk("mid_tag1", alloc_tag1, 0);
        chk("mid_ovf", ovf_err, 0);
        idle();
        cyc();
        rst_n = 1'b1;
        wait_ready("reinit_cycles");
        #1;
        chk("reinit_tag0", alloc_tag0, 64);

        // commit with nothing outstanding is illegal
        cmt_n = 2'd1; cyc();
        idle(); #1;
        chk("cmt_bad_ovf", ovf_err, 1);
        chk("cmt_bad_avail", avail, 192);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
